// File: rtl/a2d_scan_sched_pkg.sv
// Shared constants and state type for the A2D conversion scheduler.
package a2d_pkg;
    localparam int NUM_CH = 8;
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int RES_W  = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GAP   = 2'd1,
        START = 2'd2,
        CONV  = 2'd3
    } sched_state_t;
endpackage

// File: rtl/a2d_scan_sched_rr_pick.sv
// Find-first-set over the channel mask starting at ptr, wrapping; purely combinational.
module rr_pick
    import a2d_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   sel,
    output logic              any
);

    logic [CH_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        sel = '0;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = CH_W'((int'(ptr) + i) % NUM_CH);
            if (mask[idx]) sel = idx;
        end
    end

    assign any = |mask;

endmodule

// File: rtl/a2d_scan_sched.sv
// Shares one A2D interface between a round-robin channel scan and a priority one-shot requester.
// Result one clock after cnv_cmplt; GAP_CYC idle clocks between conversions; optional A2D_TIMEOUT_EN.
module a2d_scan_sched
    import a2d_pkg::*;
#(
    parameter int GAP_CYC = 16,
    parameter int TO_CYC  = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scan_en,
    input  logic [NUM_CH-1:0] en_mask,
    input  logic              req,
    input  logic [CH_W-1:0]   req_chnl,
    output logic              req_gnt,
    output logic              req_done,
    output logic              strt_cnv,
    output logic [CH_W-1:0]   chnnl,
    input  logic              cnv_cmplt,
    input  logic [RES_W-1:0]  res,
    output logic              res_vld,
    output logic [CH_W-1:0]   res_chnl,
    output logic [RES_W-1:0]  res_data,
    output logic              res_pri,
    output logic              busy
`ifdef A2D_TIMEOUT_EN
    ,
    output logic              to_err
`endif
);

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);

    sched_state_t      state, nxt;
    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   chnnl_q;
    logic [CH_W-1:0]   nxt_ptr;
    logic              pri;
    logic [GAP_W-1:0]  gap_cnt;
    logic [CH_W-1:0]   pick_sel;
    logic              pick_any;
    logic              work;
    logic              grant_pri;
    logic              grant_scan;
    logic              timeout;
    logic              finish;

    rr_pick u_pick (
        .mask (en_mask),
        .ptr  (ptr),
        .sel  (pick_sel),
        .any  (pick_any)
    );

    assign work    = req | (scan_en & pick_any);
    assign finish  = (state == CONV) && (cnv_cmplt || timeout);
    assign nxt_ptr = (chnnl_q == CH_W'(NUM_CH - 1)) ? '0 : chnnl_q + CH_W'(1);

    always_comb begin
        nxt        = state;
        grant_pri  = 1'b0;
        grant_scan = 1'b0;
        case (state)
            IDLE: begin
                if (work) nxt = START;
            end
            START: begin
                if (req)                       grant_pri  = 1'b1;
                else if (scan_en && pick_any)  grant_scan = 1'b1;
                nxt = (grant_pri || grant_scan) ? CONV : IDLE;
            end
            CONV: begin
                if (finish) nxt = GAP;
            end
            GAP: begin
                if (gap_cnt == '0) nxt = work ? START : IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // chnnl is driven straight from the arbiter in the start cycle so it is
    // valid alongside strt_cnv, then held from the register until completion.
    assign strt_cnv = grant_pri | grant_scan;
    assign req_gnt  = grant_pri;
    assign chnnl    = grant_pri  ? req_chnl :
                      grant_scan ? pick_sel : chnnl_q;
    assign busy     = (state == START) || (state == CONV) ||
                      ((state == GAP) && (gap_cnt != '0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            chnnl_q  <= '0;
            pri      <= 1'b0;
            gap_cnt  <= '0;
            res_vld  <= 1'b0;
            res_chnl <= '0;
            res_data <= '0;
            res_pri  <= 1'b0;
            req_done <= 1'b0;
        end else begin
            state    <= nxt;
            res_vld  <= 1'b0;
            req_done <= 1'b0;
            if (strt_cnv) begin
                chnnl_q <= chnnl;
                pri     <= grant_pri;
            end
            if (finish) begin
                res_vld  <= cnv_cmplt;
                req_done <= pri;
                if (cnv_cmplt) begin
                    res_data <= res;
                    res_chnl <= chnnl_q;
                    res_pri  <= pri;
                end
                // Priority conversions leave the scan position untouched.
                if (!pri) ptr <= nxt_ptr;
                gap_cnt <= GAP_LOAD;
            end else if ((state == GAP) && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

`ifdef A2D_TIMEOUT_EN
    logic [11:0] to_cnt;

    // Fires on the last CONV clock so to_err lands TO_CYC clocks after strt_cnv.
    assign timeout = (state == CONV) && !cnv_cmplt && (to_cnt == 12'(TO_CYC - 2));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt <= '0;
            to_err <= 1'b0;
        end else begin
            to_err <= timeout;
            if (state != CONV) to_cnt <= '0;
            else               to_cnt <= to_cnt + 12'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule
